// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage: load/store width codes and default depth.
package mem_stage_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  localparam int unsigned DEFAULT_MEM_WORDS = 64;

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory with per-byte write enables, asynchronous read and a
// separate asynchronous debug read port. Contents are never reset.
module data_memory #(
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             i_clk,
  input  logic [3:0]       i_we,
  input  logic [IDX_W-1:0] i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  input  logic [IDX_W-1:0] i_dbg_addr,
  output logic [31:0]      o_dbg_data
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge i_clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (i_we[lane]) begin
        mem[i_addr][lane*8 +: 8] <= i_wdata[lane*8 +: 8];
      end
    end
  end

  // Reads see pre-write contents during a same-cycle store.
  assign o_rdata    = mem[i_addr];
  assign o_dbg_data = mem[i_dbg_addr];

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: byte-lane stores, extended loads, MEM/WB register.
// Optional alignment checking is enabled by defining MEMORY_ACCESS_ALIGN_CHECK_EN.
module memory_access
  import mem_stage_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_halt,
  input  logic        i_ctl_MEM_mem_read,
  input  logic        i_ctl_MEM_mem_write,
  input  logic        i_ctl_MEM_unsigned,
  input  logic [1:0]  i_ctl_MEM_data_width,
  input  logic        i_ctl_WB_mem_to_reg,
  input  logic        i_ctl_WB_reg_write,
  input  logic [31:0] i_ALU_result,
  input  logic [31:0] i_data_to_write,
  input  logic [4:0]  i_reg_dest,
  input  logic [7:0]  i_debug_addr,
  output logic [31:0] o_debug_data,
  output logic [31:0] o_read_data,
  output logic [31:0] o_ALU_result,
  output logic [4:0]  o_reg_dest,
  output logic        o_ctl_WB_mem_to_reg,
  output logic        o_ctl_WB_reg_write,
`ifdef MEMORY_ACCESS_ALIGN_CHECK_EN
  output logic        o_misaligned,
`endif
  output logic [4:0]  o_reg_dest_wire,
  output logic        o_reg_write_wire
);

  localparam int unsigned IdxW = $clog2(MEM_WORDS);

  logic [IdxW-1:0] word_idx;
  logic [IdxW-1:0] dbg_idx;
  logic [1:0]      offset;
  logic [3:0]      lane_sel;
  logic [3:0]      lane_we;
  logic [31:0]     wdata;
  logic [31:0]     rword;
  logic [31:0]     load_val;
  logic [7:0]      byte_val;
  logic [15:0]     half_val;
  logic            misaligned;
  logic            unused_debug_addr;

  // Address bits above the memory range are dropped, giving wrap-around.
  assign word_idx          = i_ALU_result[IdxW+1:2];
  assign offset            = i_ALU_result[1:0];
  assign dbg_idx           = IdxW'(i_debug_addr);
  assign unused_debug_addr = ^i_debug_addr;

  assign o_reg_dest_wire  = i_reg_dest;
  assign o_reg_write_wire = i_ctl_WB_reg_write;

  always_comb begin
    lane_sel = 4'b1111;
    wdata    = i_data_to_write;
    case (i_ctl_MEM_data_width)
      WIDTH_BYTE: begin
        lane_sel = 4'b0001 << offset;
        wdata    = {4{i_data_to_write[7:0]}};
      end
      WIDTH_HALF: begin
        lane_sel = offset[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{i_data_to_write[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEMORY_ACCESS_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (i_ctl_MEM_mem_read || i_ctl_MEM_mem_write) begin
      if (i_ctl_MEM_data_width == WIDTH_HALF) begin
        misaligned = offset[0];
      end else if (i_ctl_MEM_data_width != WIDTH_BYTE) begin
        misaligned = (offset != 2'b00);
      end
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  assign lane_we = (i_ctl_MEM_mem_write && !i_halt && !i_reset && !misaligned) ? lane_sel : 4'b0000;

  data_memory #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IdxW)
  ) u_data_memory (
    .i_clk      (i_clk),
    .i_we       (lane_we),
    .i_addr     (word_idx),
    .i_wdata    (wdata),
    .o_rdata    (rword),
    .i_dbg_addr (dbg_idx),
    .o_dbg_data (o_debug_data)
  );

  assign byte_val = rword[{offset, 3'b000} +: 8];
  assign half_val = offset[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_val = rword;
    case (i_ctl_MEM_data_width)
      WIDTH_BYTE: load_val = i_ctl_MEM_unsigned ? {24'h0, byte_val}
                                                : {{24{byte_val[7]}}, byte_val};
      WIDTH_HALF: load_val = i_ctl_MEM_unsigned ? {16'h0, half_val}
                                                : {{16{half_val[15]}}, half_val};
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_read_data         <= '0;
      o_ALU_result        <= '0;
      o_reg_dest          <= '0;
      o_ctl_WB_mem_to_reg <= 1'b0;
      o_ctl_WB_reg_write  <= 1'b0;
`ifdef MEMORY_ACCESS_ALIGN_CHECK_EN
      o_misaligned        <= 1'b0;
`endif
    end else if (!i_halt) begin
      o_read_data         <= i_ctl_MEM_mem_read ? load_val : 32'h0;
      o_ALU_result        <= i_ALU_result;
      o_reg_dest          <= i_reg_dest;
      o_ctl_WB_mem_to_reg <= i_ctl_WB_mem_to_reg;
      o_ctl_WB_reg_write  <= i_ctl_WB_reg_write;
`ifdef MEMORY_ACCESS_ALIGN_CHECK_EN
      o_misaligned        <= misaligned;
`endif
    end
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, data memory depth in 32-bit words (byte address width = log2(MEM_WORDS*4)).
REQ-002 SHALL use one clock and a synchronous, active-high reset: i_clk  in  1  rising-edge clock.
REQ-003 SHALL have i_reset  in  1  synchronous active-high reset.
REQ-004 SHALL have i_halt  in  1  freeze pipeline register and block memory writes.
REQ-005 SHALL have i_ctl_MEM_mem_read, i_ctl_MEM_mem_write, i_ctl_MEM_unsigned  in  1 each  load enable, store enable, zero-extend loads.
REQ-006 SHALL have i_ctl_MEM_data_width  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 SHALL have i_ctl_WB_mem_to_reg, i_ctl_WB_reg_write  in  1 each  passed to WB.
REQ-008 SHALL have i_ALU_result  in  32  byte address / passthrough result; i_data_to_write  in  32  store data; i_reg_dest  in  5  destination register.
REQ-009 SHALL have i_debug_addr  in  8  debug word index; o_debug_data  out  32  combinational word at that index.
REQ-010 SHALL have o_read_data, o_ALU_result  out  32 each; o_reg_dest  out  5; o_ctl_WB_mem_to_reg, o_ctl_WB_reg_write  out  1 each (all registered MEM/WB).
REQ-011 SHALL have o_reg_dest_wire  out  5  and o_reg_write_wire  out  1  combinational copies of i_reg_dest / i_ctl_WB_reg_write for forwarding.

Function
REQ-012 SHALL store data little-endian in four byte lanes; word index = address[log2(MEM_WORDS)+1:2], byte offset = address[1:0].
REQ-013 SHALL write on the rising edge when mem_write=1 and i_halt=0: byte writes lane offset, half writes lanes offset and offset+1 (offset[0] ignored), word writes all lanes (offset ignored).
REQ-014 SHALL read combinationally in the same cycle and register the extracted value into o_read_data one cycle later (load latency 1 cycle to WB).
REQ-015 SHALL sign-extend byte/half loads when unsigned=0 and zero-extend when unsigned=1; word loads ignore unsigned.
REQ-016 SHALL register o_read_data = 0 when mem_read=0.
REQ-017 SHALL, with i_halt=1 and i_reset=0, hold every registered output and write nothing.
REQ-018 SHALL give reset priority over halt; simultaneous read and write to the same address returns pre-write data.
REQ-019 SHALL ignore address bits above the memory range (wrap-around modulo MEM_WORDS*4).
REQ-020 SHALL reflect the same-edge store in o_debug_data on the following cycle.

Reset
REQ-021 SHALL clear o_read_data, o_ALU_result, o_reg_dest, o_ctl_WB_mem_to_reg, o_ctl_WB_reg_write to 0 on reset.
REQ-022 SHALL block memory writes during reset cycles and SHALL NOT clear memory contents.

Configuration
REQ-023 SHALL, with MEMORY_ACCESS_ALIGN_CHECK_EN defined, add o_misaligned (out 1, registered, reset 0), set for one cycle when a half access has offset[0]=1 or a word access has offset!=0, and suppress that store.
REQ-024 SHALL, without the macro, omit o_misaligned and perform misaligned accesses per REQ-013.

Structure
REQ-025 SHALL place data-width codes (WIDTH_BYTE/HALF/WORD) and default MEM_WORDS in shared package mem_stage_pkg.
REQ-026 SHALL implement storage in sub-module data_memory (byte-lane write enables, async read, debug read port); lane selection and extension stay in memory_access.

Verification
REQ-027 SHALL cover: word store 0xDEADBEEF at 0x10, then lw 0x10 -> o_read_data=0xDEADBEEF next cycle.
REQ-028 SHALL cover: lb 0x13 signed -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
REQ-029 SHALL cover: sb 0x55 at 0x11 over 0xDEADBEEF -> o_debug_data(index 4)=0xDEAD55EF.
REQ-030 SHALL cover: i_halt=1 with sw 0x12345678 to 0x20 -> memory and outputs unchanged; release -> write occurs.
REQ-031 SHALL cover: reset asserted mid-stream with mem_write=1 -> outputs 0, memory unchanged.
REQ-032 SHALL cover (macro on): sw to 0x22 -> o_misaligned=1 next cycle, word 8 unchanged.
